// File: rtl/shift64_pkg.sv
// rtl/shift64_pkg.sv - shared constants, types and helpers for the 64-bit deserialiser
package shift64_pkg;

  localparam int W     = 64;
  localparam int CHUNK = 8;
  localparam int CNT_W = 7;

  typedef logic [CNT_W-1:0] count_t;

  typedef enum logic {
    MODE_BIT   = 1'b0,
    MODE_CHUNK = 1'b1
  } mode_e;

  // Left shift that moves a count-bit accumulation up to the word MSB.
  function automatic count_t align_shift(input count_t count);
    return count_t'(W) - count;
  endfunction

endpackage

// File: rtl/shift64_hold.sv
// rtl/shift64_hold.sv - one-entry valid/ready holding register carrying data plus a bit count
module shift64_hold #(
  parameter int DATA_W = 64,
  parameter int BITS_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic [BITS_W-1:0] load_bits,
  output logic              load_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [BITS_W-1:0] out_bits
);

  // A new entry may replace the current one on the same edge it drains.
  assign load_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_bits  <= '0;
    end else if (load_valid && load_ready) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_bits  <= load_bits;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/shift64_deser.sv
// rtl/shift64_deser.sv - reassembles MSB-first 1-bit/8-bit chunks into left-aligned 64-bit words
module shift64_deser
  import shift64_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [CHUNK-1:0] in_data,
  input  logic             in_last,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [CNT_W-1:0] out_bits,
  output logic             err_overflow
);

  logic [W-1:0] acc;
  count_t       count;
  logic         full;

  count_t       room;
  count_t       take;
  count_t       new_count;
  logic [W-1:0] chunk_ext;
  logic [W-1:0] new_acc;
  logic         wide;
  logic         trunc;
  logic         accept;
  logic         complete;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_data;
  count_t       load_bits;

  assign in_ready = !full && !flush;
  assign accept   = in_valid && in_ready;

  // A wide chunk that does not fit contributes only its top 'room' bits.
  always_comb begin
    room      = count_t'(W) - count;
    wide      = (mode_e'(in_mode) == MODE_CHUNK);
    trunc     = wide && (room < count_t'(CHUNK));
    take      = count_t'(1);
    chunk_ext = {{(W-1){1'b0}}, in_data[0]};
    if (wide) begin
      take      = trunc ? room : count_t'(CHUNK);
      chunk_ext = {{(W-CHUNK){1'b0}}, in_data} >> (count_t'(CHUNK) - take);
    end
    new_acc   = (acc << take) | chunk_ext;
    new_count = count + take;
    complete  = accept && ((new_count == count_t'(W)) || in_last);
  end

  // While frozen, the stored word is offered to the holding register each cycle.
  always_comb begin
    load_valid = complete || (full && !flush);
    load_data  = new_acc << align_shift(new_count);
    load_bits  = new_count;
    if (full) begin
      load_data = acc << align_shift(count);
      load_bits = count;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      count        <= '0;
      full         <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      err_overflow <= accept && trunc;
      if (flush) begin
        acc   <= '0;
        count <= '0;
        full  <= 1'b0;
      end else if (full) begin
        if (load_ready) begin
          acc   <= '0;
          count <= '0;
          full  <= 1'b0;
        end
      end else if (accept) begin
        if (complete && load_ready) begin
          acc   <= '0;
          count <= '0;
        end else begin
          acc   <= new_acc;
          count <= new_count;
          full  <= complete;
        end
      end
    end
  end

  shift64_hold #(
    .DATA_W(W),
    .BITS_W(CNT_W)
  ) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_bits (load_bits),
    .load_ready(load_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_bits  (out_bits)
  );

endmodule

// File: tb/tb_shift64_deser.sv
// tb/tb_shift64_deser.sv - scoreboard bench for shift64_deser
module tb_shift64_deser;
  import shift64_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_mode = 1'b0;
  logic [CHUNK-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     out_data;
  logic [CNT_W-1:0] out_bits;
  logic             err_overflow;

  typedef struct {
    logic [W-1:0]     data;
    logic [CNT_W-1:0] bits;
  } exp_t;

  exp_t         sb[$];
  bit           mq[$];
  bit           ovf_pend = 1'b0;
  int           ovf_seen = 0;
  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] last_data = '0;
  logic [6:0]   last_bits = '0;

  always #5 clk = ~clk;

  shift64_deser dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_mode     (in_mode),
    .in_data     (in_data),
    .in_last     (in_last),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_bits    (out_bits),
    .err_overflow(err_overflow)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: compare outputs with the model, advance the model, then advance the clock.
  task automatic step();
    bit   drain_now;
    bit   accept_now;
    int   room;
    int   take_n;
    exp_t e;
    #1;
    chk("in_ready", in_ready, (sb.size() < 2 && !flush));
    chk("out_valid", out_valid, sb.size() > 0);
    chk("err_overflow", err_overflow, ovf_pend);
    if (err_overflow) ovf_seen++;
    drain_now  = (sb.size() > 0) && out_ready;
    accept_now = in_valid && !flush && (sb.size() < 2);
    if (drain_now) begin
      chk("out_data", out_data, sb[0].data);
      chk("out_bits", out_bits, sb[0].bits);
      last_data = out_data;
      last_bits = out_bits;
    end
    ovf_pend = 1'b0;
    if (flush) begin
      if (sb.size() == 2) void'(sb.pop_back());
      mq.delete();
    end
    if (drain_now) void'(sb.pop_front());
    if (accept_now) begin
      if (in_mode == MODE_BIT) begin
        mq.push_back(in_data[0]);
      end else begin
        room   = W - mq.size();
        take_n = (room < CHUNK) ? room : CHUNK;
        if (room < CHUNK) ovf_pend = 1'b1;
        for (int i = 0; i < take_n; i++) mq.push_back(in_data[CHUNK-1-i]);
      end
      if (mq.size() == W || in_last) begin
        e.data = '0;
        for (int i = 0; i < mq.size(); i++) e.data[W-1-i] = mq[i];
        e.bits = 7'(mq.size());
        sb.push_back(e);
        mq.delete();
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic m, input logic [CHUNK-1:0] d, input logic l);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    in_last  = l;
    while (sb.size() >= 2 && guard < 100) begin
      step();
      guard++;
    end
    if (guard >= 100) chk("send_timeout", 1, 0);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    mq.delete();
    ovf_pend = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_bits", out_bits, 0);
    chk("rst_err", err_overflow, 0);
    @(negedge clk);
  endtask

  initial begin
    do_reset();

    out_ready = 1'b1;
    last_data = '0;
    for (int i = 1; i <= 8; i++) send(MODE_CHUNK, 8'(i), 1'b0);
    idle(2);
    chk("wide_data", last_data, 64'h0102030405060708);
    chk("wide_bits", last_bits, 64);

    last_data = '0;
    send(MODE_BIT, 8'h01, 1'b0);
    send(MODE_BIT, 8'h00, 1'b0);
    send(MODE_BIT, 8'h01, 1'b1);
    idle(2);
    chk("short_data", last_data, 64'hA000000000000000);
    chk("short_bits", last_bits, 3);

    last_data = '0;
    ovf_seen  = 0;
    for (int i = 0; i < 7; i++) send(MODE_CHUNK, 8'hFF, 1'b0);
    for (int i = 0; i < 4; i++) send(MODE_BIT, 8'h00, 1'b0);
    send(MODE_CHUNK, 8'hAB, 1'b0);
    idle(3);
    chk("ovf_data", last_data, 64'hFFFFFFFFFFFFFF0A);
    chk("ovf_bits", last_bits, 64);
    chk("ovf_pulses", ovf_seen, 1);

    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(MODE_CHUNK, 8'(8'h20 + i), 1'b0);
    for (int i = 1; i <= 8; i++) send(MODE_CHUNK, 8'(8'h30 + i), 1'b0);
    idle(2);
    chk("bp_stall", in_ready, 0);
    out_ready = 1'b1;
    step();
    chk("bp_word1", last_data, 64'h2122232425262728);
    chk("bp_ready_back", in_ready, 1);
    step();
    chk("bp_word2", last_data, 64'h3132333435363738);
    idle(1);

    last_data = '0;
    for (int i = 0; i < 3; i++) send(MODE_CHUNK, 8'h55, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h77;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) send(MODE_CHUNK, 8'h11, 1'b0);
    idle(2);
    chk("flush_data", last_data, 64'h1111111111111111);

    last_data = '0;
    for (int i = 0; i < 3; i++) send(MODE_CHUNK, 8'h55, 1'b0);
    do_reset();
    for (int i = 0; i < 8; i++) send(MODE_CHUNK, 8'h11, 1'b0);
    idle(2);
    chk("reset_data", last_data, 64'h1111111111111111);

    for (int i = 0; i < 1500; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      in_valid  = 1'($urandom_range(0, 1));
      in_mode   = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      in_last   = ($urandom_range(0, 15) == 0);
      step();
    end
    flush     = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
